// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, mux/ALU encodings, data-processing commands and condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // flags are {N,Z,C,V}; the reserved code 1111 never executes
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, res;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_condunit.sv
// Condition unit: flag register, condition evaluation latched at DECODE,
// and the condition-gated PC/register/memory write enables.
module mc_condunit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       latch_cond,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       next_pc,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);

    logic [3:0] flags;
    logic       cond_ex_reg;

    // Later states gate only on the latched result, so an S-suffixed update
    // in EXECUTE cannot re-gate the same instruction's writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags       <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            if (latch_cond)
                cond_ex_reg <= cond_check(cond, flags);
            if (flag_w[1] && cond_ex_reg)
                flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex_reg)
                flags[1:0] <= alu_flags[1:0];
        end
    end

    assign pc_write  = next_pc | (pcs & cond_ex_reg);
    assign reg_write = reg_w & cond_ex_reg;
    assign mem_write = mem_w & cond_ex_reg;

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM + ALU decode for the multicycle ARM-subset datapath.
// Define MC_WAITSTATE_EN to honour MemReady in FETCH/MEMRD/MEMWR; otherwise it is ignored.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic         MemReady,
    output logic         PCWrite,
    output logic         MemWrite,
    output logic         RegWrite,
    output logic         IRWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUControl
);

    state_t     state;
    state_t     st;
    logic       mem_ready;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       next_pc, reg_w, mem_w, branch, alu_op, no_write, pcs;
    logic [1:0] flag_w;
    logic       unused_rn;

`ifdef MC_WAITSTATE_EN
    assign mem_ready = MemReady;
`else
    logic unused_mem_ready;
    assign mem_ready        = 1'b1;
    assign unused_mem_ready = MemReady;
`endif

    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instr[19:16];

    assign ImmSrc = Instr[25:24];
    assign RegSrc = {op == 2'b01, op == 2'b10};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        2'b01:   state <= S_MEMADR;
                        2'b00:   state <= funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b10:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:    if (mem_ready) state <= S_MEMWB;
                S_MEMWR:    if (mem_ready) state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // While reset is high the outputs behave as an idle FETCH with no writes.
    assign st = reset ? S_FETCH : state;

    always_comb begin
        next_pc   = 1'b0;
        IRWrite   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (st)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready && !reset) begin
                    IRWrite = 1'b1;
                    next_pc = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMRD:    AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB:    reg_w = ~no_write;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign no_write = (cmd == CMD_CMP);

    always_comb begin
        ALUControl = ALU_ADD;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: ALUControl = ALU_SUB;
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

    // C/V only move for arithmetic ops; logical ops touch N/Z alone
    always_comb begin
        flag_w = 2'b00;
        if (alu_op && funct[0])
            flag_w = {1'b1, (ALUControl == ALU_ADD) || (ALUControl == ALU_SUB)};
    end

    assign pcs = ((Instr[15:12] == 4'hF) && reg_w) || branch;

    mc_condunit u_condunit (
        .clk       (clk),
        .reset     (reset),
        .cond      (Instr[31:28]),
        .alu_flags (ALUFlags),
        .latch_cond(st == S_DECODE),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .next_pc   (next_pc),
        .pc_write  (PCWrite),
        .reg_write (RegWrite),
        .mem_write (MemWrite)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes its expected
// per-cycle output vectors, which are popped and compared as the cycles run.
module tb_multicycle_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         MemReady;
    logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]   ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .ALUFlags  (ALUFlags),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    // vector: {ImmSrc, RegSrc, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
    typedef struct {
        string        name;
        logic         rst;
        logic         mr;
        logic [31:12] ins;
        logic [3:0]   fl;
        logic [15:0]  v;
        logic [15:0]  m;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] mk(input logic [31:12] ins, input logic [3:0] en,
                                       input logic adr, input logic srca,
                                       input logic [1:0] srcb, input logic [1:0] ress,
                                       input logic [1:0] aluc);
        logic [1:0] op;
        op = ins[27:26];
        return {ins[25:24], op == 2'b01, op == 2'b10, en, adr, srca, srcb, ress, aluc};
    endfunction

    task automatic push(input string name, input logic rst, input logic mr, input logic [31:12] ins,
                        input logic [3:0] fl, input logic [15:0] v, input logic [15:0] m);
        ent_t e;
        e.name = name; e.rst = rst; e.mr = mr; e.ins = ins; e.fl = fl; e.v = v; e.m = m;
        sb.push_back(e);
    endtask

    task automatic step(input ent_t e, output logic [15:0] act);
        reset    = e.rst;
        MemReady = e.mr;
        Instr    = e.ins;
        ALUFlags = e.fl;
        @(negedge clk);
        act = {ImmSrc, RegSrc, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl};
        @(posedge clk);
        #1;
    endtask

    // Expected cycle sequence of one instruction; g = expected condition outcome.
    // fw/mw = wait cycles requested in FETCH and in MEMRD/MEMWR.
    task automatic seq(input logic [31:12] ins, input logic [3:0] fl, input logic g,
                       input int fw, input int mw);
        logic       mr_go;
        int         nw;
        logic       rd15;
        logic [3:0] cmd;
        logic [1:0] aluc;
        logic       w;
        rd15 = (ins[15:12] == 4'hF);
`ifdef MC_WAITSTATE_EN
        for (int i = 0; i < fw; i++)
            push("FETCH_WAIT", 0, 0, ins, fl, mk(ins, 4'b0000, 0, 1, 2'b10, 2'b10, 2'b00), 16'hFFFF);
        mr_go = 1'b1;
        nw    = mw;
`else
        mr_go = (fw == 0) && (mw == 0);
        nw    = 0;
`endif
        push("FETCH", 0, mr_go, ins, fl, mk(ins, 4'b1001, 0, 1, 2'b10, 2'b10, 2'b00), 16'hFFFF);
        push("DECODE", 0, 1, ins, fl, mk(ins, 4'b0000, 0, 1, 2'b10, 2'b10, 2'b00), 16'hFF7F);
        case (ins[27:26])
            2'b01: begin
                push("MEMADR", 0, 1, ins, fl, mk(ins, 4'b0000, 0, 0, 2'b01, 2'b00, 2'b00), 16'hFF73);
                if (ins[20]) begin
                    for (int i = 0; i < nw; i++)
                        push("MEMRD_WAIT", 0, 0, ins, fl, mk(ins, 4'b0000, 1, 0, 2'b00, 2'b00, 2'b00), 16'hFF83);
                    push("MEMRD", 0, mr_go, ins, fl, mk(ins, 4'b0000, 1, 0, 2'b00, 2'b00, 2'b00), 16'hFF83);
                    push("MEMWB", 0, 1, ins, fl, mk(ins, {g & rd15, 1'b0, g, 1'b0}, 0, 0, 2'b00, 2'b01, 2'b00), 16'hFF0F);
                end else begin
                    for (int i = 0; i < nw; i++)
                        push("MEMWR_WAIT", 0, 0, ins, fl, mk(ins, {1'b0, g, 2'b00}, 1, 0, 2'b00, 2'b00, 2'b00), 16'hFF83);
                    push("MEMWR", 0, mr_go, ins, fl, mk(ins, {1'b0, g, 2'b00}, 1, 0, 2'b00, 2'b00, 2'b00), 16'hFF83);
                end
            end
            2'b00: begin
                cmd = ins[24:21];
                case (cmd)
                    4'b0100: aluc = 2'b00;
                    4'b0010: aluc = 2'b01;
                    4'b0000: aluc = 2'b10;
                    4'b1100: aluc = 2'b11;
                    4'b1010: aluc = 2'b01;
                    default: aluc = 2'b00;
                endcase
                w = g & (cmd != 4'b1010);
                push(ins[25] ? "EXECUTEI" : "EXECUTER", 0, 1, ins, fl,
                     mk(ins, 4'b0000, 0, 0, ins[25] ? 2'b01 : 2'b00, 2'b00, aluc), 16'hFF73);
                push("ALUWB", 0, 1, ins, fl, mk(ins, {w & rd15, 1'b0, w, 1'b0}, 0, 0, 2'b00, 2'b00, 2'b00), 16'hFF0F);
            end
            2'b10:
                push("BRANCH", 0, 1, ins, fl, mk(ins, {g, 3'b000}, 0, 0, 2'b01, 2'b10, 2'b00), 16'hFF7F);
            default: ;
        endcase
    endtask

    task automatic test_reset;
        ent_t e;
        logic [15:0] act;
        for (int i = 0; i < 2; i++)
            push("RESET", 1, 1, 20'hE0821, 4'b1111, mk(20'hE0821, 4'b0000, 0, 1, 2'b10, 2'b10, 2'b00), 16'hFFFF);
        seq(20'h1A000, 4'b0000, 1'b1, 0, 0);   // BNE taken: Z cleared by reset
        seq(20'h0A000, 4'b0000, 1'b0, 0, 0);   // BEQ not taken
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, act);
            n_cmp++;
            if ((act & e.m) !== (e.v & e.m)) begin
                n_bad++;
                $display("FAIL reset/%s: got %h need %h (mask %h)", e.name, act & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    task automatic test_dataproc;
        ent_t e;
        logic [15:0] act;
        seq(20'hE0821, 4'b0000, 1'b1, 0, 0);   // ADD R1,R2,R3
        seq(20'hE0021, 4'b0000, 1'b1, 0, 0);   // AND
        seq(20'hE1821, 4'b0000, 1'b1, 0, 0);   // ORR
        seq(20'hE0221, 4'b0000, 1'b1, 0, 0);   // EOR -> defaults to ADD
        seq(20'hE2821, 4'b0000, 1'b1, 0, 0);   // ADD immediate
        seq(20'hEC000, 4'b0000, 1'b1, 0, 0);   // Op 11 NOP
        seq(20'hE0821, 4'b0000, 1'b1, 2, 0);   // ADD with fetch wait
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, act);
            n_cmp++;
            if ((act & e.m) !== (e.v & e.m)) begin
                n_bad++;
                $display("FAIL dataproc/%s: got %h need %h (mask %h)", e.name, act & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    task automatic test_ldr_str;
        ent_t e;
        logic [15:0] act;
        int mw_cnt;
        int mw_exp;
        mw_cnt = 0;
`ifdef MC_WAITSTATE_EN
        mw_exp = 3;
`else
        mw_exp = 1;
`endif
        seq(20'hE5921, 4'b0000, 1'b1, 0, 2);   // LDR R1,[R2]
        seq(20'hE5821, 4'b0000, 1'b1, 0, 2);   // STR R1,[R2]
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, act);
            if (act[10]) mw_cnt++;
            n_cmp++;
            if ((act & e.m) !== (e.v & e.m)) begin
                n_bad++;
                $display("FAIL ldr_str/%s: got %h need %h (mask %h)", e.name, act & e.m, e.v & e.m, e.m);
            end
        end
        n_cmp++;
        if (mw_cnt !== mw_exp) begin
            n_bad++;
            $display("FAIL memwrite_cycles: got %0d need %0d", mw_cnt, mw_exp);
        end
    endtask

    task automatic test_cmp_branch;
        ent_t e;
        logic [15:0] act;
        seq(20'hE1510, 4'b0100, 1'b1, 0, 0);   // CMP, Z=1
        seq(20'h0A000, 4'b0000, 1'b1, 0, 0);   // BEQ taken
        seq(20'hE1510, 4'b0000, 1'b1, 0, 0);   // CMP, Z=0
        seq(20'h0A000, 4'b0000, 1'b0, 0, 0);   // BEQ not taken
        seq(20'hE1510, 4'b0010, 1'b1, 0, 0);   // CMP, C=1
        seq(20'hE1911, 4'b0000, 1'b1, 0, 0);   // ORRS keeps C
        seq(20'h2A000, 4'b0000, 1'b1, 0, 0);   // BCS taken
        seq(20'hFA000, 4'b0000, 1'b0, 0, 0);   // cond 1111 never
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, act);
            n_cmp++;
            if ((act & e.m) !== (e.v & e.m)) begin
                n_bad++;
                $display("FAIL cmp_branch/%s: got %h need %h (mask %h)", e.name, act & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    task automatic test_subne_pcwrite;
        ent_t e;
        logic [15:0] act;
        seq(20'hE1510, 4'b0100, 1'b1, 0, 0);   // CMP, Z=1
        seq(20'h10521, 4'b0000, 1'b0, 0, 0);   // SUBNES squashed
        seq(20'h0A000, 4'b0000, 1'b1, 0, 0);   // BEQ still taken
        seq(20'hE081F, 4'b0000, 1'b1, 0, 0);   // ADD PC,R1,R2
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, act);
            n_cmp++;
            if ((act & e.m) !== (e.v & e.m)) begin
                n_bad++;
                $display("FAIL subne_pc/%s: got %h need %h (mask %h)", e.name, act & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    task automatic test_reset_mid;
        ent_t e;
        logic [15:0] act;
        seq(20'hE1510, 4'b0100, 1'b1, 0, 0);   // set Z=1
        seq(20'hE5821, 4'b0000, 1'b1, 0, 1);   // STR, last MEMWR cycle replaced by reset
        void'(sb.pop_back());
        push("RESET_MEMWR", 1, 1, 20'hE5821, 4'b0000, mk(20'hE5821, 4'b0000, 0, 1, 2'b10, 2'b10, 2'b00), 16'hFFFF);
        seq(20'h0A000, 4'b0000, 1'b0, 0, 0);   // BEQ not taken: flags cleared
        while (sb.size() > 0) begin
            e = sb.pop_front();
            step(e, act);
            n_cmp++;
            if ((act & e.m) !== (e.v & e.m)) begin
                n_bad++;
                $display("FAIL reset_mid/%s: got %h need %h (mask %h)", e.name, act & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        MemReady = 1'b1;
        Instr    = '0;
        ALUFlags = '0;
        test_reset();
        test_dataproc();
        test_ldr_str();
        test_cmp_branch();
        test_subne_pcwrite();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
